// File: rtl/sound_gen.sv
// rtl/sound_gen.sv - Super Bug sound generator: motor tone, crash and skid noise, delta-sigma output
module sound_gen #(
    parameter int          PRESCALE    = 64,
    parameter logic [11:0] MOTOR_BASE  = 12'd8,
    parameter logic [11:0] MOTOR_STEP  = 12'd6,
    parameter int          DECAY_TICKS = 4096,
    parameter logic [3:0]  SKID_AMP    = 4'd10
) (
    input  logic       Clk6,
    input  logic       Reset_n,
    input  logic       Attract,
    input  logic       MotorSnd_n,
    input  logic       CrashSnd_n,
    input  logic       SkidSnd_n,
    input  logic [7:0] DBus,
    output logic [7:0] Audio_S,
    output logic       Audio_O
);

    localparam int PW = $clog2(PRESCALE);
    localparam int DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DECAY_LAST    = DW'(DECAY_TICKS - 1);

    logic [2:0]    snd_cur;
    logic [2:0]    snd_prev;
    logic [2:0]    snd_wr;
    logic [PW-1:0] prescaler;
    logic          tick;
    logic          mix_en;
    logic [3:0]    motor_spd;
    logic [11:0]   motor_acc;
    logic [11:0]   motor_inc;
    logic [3:0]    crash_amp;
    logic [DW-1:0] decay_cnt;
    logic          skid_on;
    logic [15:0]   lfsr;
    logic          lfsr_fb;
    logic [3:0]    crash_lvl;
    logic [3:0]    skid_lvl;
    logic [5:0]    mix_sum;
    logic [7:0]    ds_acc;
    logic [8:0]    ds_next;

    // Strobe order in the history registers: {skid, crash, motor}
    always_ff @(posedge Clk6 or negedge Reset_n) begin
        if (!Reset_n) begin
            snd_cur  <= 3'b111;
            snd_prev <= 3'b111;
        end else begin
            snd_cur  <= {SkidSnd_n, CrashSnd_n, MotorSnd_n};
            snd_prev <= snd_cur;
        end
    end

    assign snd_wr = snd_prev & ~snd_cur;

    always_ff @(posedge Clk6 or negedge Reset_n) begin
        if (!Reset_n) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    assign tick      = (prescaler == PRESCALE_LAST);
    assign motor_inc = MOTOR_BASE + MOTOR_STEP * {8'd0, motor_spd};
    assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge Clk6 or negedge Reset_n) begin
        if (!Reset_n) begin
            motor_spd <= 4'd0;
            motor_acc <= 12'd0;
            lfsr      <= 16'hACE1;
        end else begin
            if (snd_wr[0]) begin
                motor_spd <= DBus[3:0];
            end
            if (tick) begin
                motor_acc <= motor_acc + motor_inc;
                lfsr      <= {lfsr[14:0], lfsr_fb};
            end
        end
    end

    // A crash write takes priority over a decay step landing in the same cycle
    always_ff @(posedge Clk6 or negedge Reset_n) begin
        if (!Reset_n) begin
            crash_amp <= 4'd0;
            decay_cnt <= '0;
            skid_on   <= 1'b0;
        end else if (Attract) begin
            crash_amp <= 4'd0;
            decay_cnt <= '0;
            skid_on   <= 1'b0;
        end else begin
            if (snd_wr[1]) begin
                crash_amp <= DBus[7:4];
                decay_cnt <= '0;
            end else if (tick && crash_amp != 4'd0) begin
                if (decay_cnt == DECAY_LAST) begin
                    decay_cnt <= '0;
                    crash_amp <= crash_amp - 4'd1;
                end else begin
                    decay_cnt <= decay_cnt + 1'b1;
                end
            end
            if (snd_wr[2]) begin
                skid_on <= DBus[7];
            end
        end
    end

    assign crash_lvl = lfsr[0] ? crash_amp : 4'd0;
    assign skid_lvl  = (skid_on && lfsr[3]) ? SKID_AMP : 4'd0;
    assign mix_sum   = {2'b00, motor_acc[11:8]} + {2'b00, crash_lvl} + {2'b00, skid_lvl};

    // Mixer samples one cycle after the tick so it sees the post-tick voice state
    always_ff @(posedge Clk6 or negedge Reset_n) begin
        if (!Reset_n) begin
            mix_en  <= 1'b0;
            Audio_S <= 8'd0;
        end else begin
            mix_en <= tick;
            if (mix_en) begin
                Audio_S <= Attract ? 8'd0 : {mix_sum, 2'b00};
            end
        end
    end

    assign ds_next = {1'b0, ds_acc} + {1'b0, Audio_S};

    always_ff @(posedge Clk6 or negedge Reset_n) begin
        if (!Reset_n) begin
            ds_acc  <= 8'd0;
            Audio_O <= 1'b0;
        end else begin
            ds_acc  <= ds_next[7:0];
            Audio_O <= ds_next[8];
        end
    end

endmodule

// File: tb/tb_sound_gen.sv
// tb/tb_sound_gen.sv - directed bench for sound_gen with PRESCALE=4, DECAY_TICKS=4
module tb_sound_gen;

    logic       Clk6 = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Attract = 1'b0;
    logic       MotorSnd_n = 1'b1;
    logic       CrashSnd_n = 1'b1;
    logic       SkidSnd_n = 1'b1;
    logic [7:0] DBus = 8'h00;
    logic [7:0] Audio_S;
    logic       Audio_O;

    int vectors = 0;
    int miscompares = 0;

    sound_gen #(
        .PRESCALE   (4),
        .MOTOR_BASE (12'd8),
        .MOTOR_STEP (12'd6),
        .DECAY_TICKS(4),
        .SKID_AMP   (4'd10)
    ) dut (
        .Clk6      (Clk6),
        .Reset_n   (Reset_n),
        .Attract   (Attract),
        .MotorSnd_n(MotorSnd_n),
        .CrashSnd_n(CrashSnd_n),
        .SkidSnd_n (SkidSnd_n),
        .DBus      (DBus),
        .Audio_S   (Audio_S),
        .Audio_O   (Audio_O)
    );

    always #5 Clk6 = ~Clk6;

    // Running duty check: ones emitted so far must equal floor(sum of samples / 256)
    int ds_ones = 0;
    int ds_sum  = 0;
    int ds_errs = 0;
    always @(negedge Clk6) begin
        if (!Reset_n) begin
            ds_ones = 0;
            ds_sum  = 0;
        end else begin
            ds_ones = ds_ones + int'(Audio_O);
            if (ds_ones != (ds_sum >> 8)) ds_errs++;
            ds_sum = ds_sum + int'(Audio_S);
        end
    end

    typedef struct {
        bit          rst;
        bit          attract;
        bit [2:0]    strb;
        logic [7:0]  dbus;
        int          ticks;
        logic [3:0]  spd;
        logic [3:0]  crash;
        logic        skid;
        logic [11:0] delta;
        bit          chk_s;
        logic [7:0]  exp_s;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int g = 0;
            while (!dut.tick && g < 100) begin
                @(negedge Clk6);
                g++;
            end
            if (g >= 100) begin
                vectors++;
                miscompares++;
                $display("FAIL tick_timeout: got no tick in %0d cycles, expected one", g);
            end
            @(negedge Clk6);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk6);
        #1 Reset_n = 1'b0;
        repeat (2) @(negedge Clk6);
        #1 Reset_n = 1'b1;
    endtask

    initial begin
        logic [15:0] lf;
        logic [11:0] acc0;
        logic [11:0] d;
        int          bad;

        // rst, attract, {skid,crash,motor}, dbus, ticks, spd, crash, skid, delta, chk_s, exp_s
        tbl[0]  = '{1, 0, 3'b001, 8'h03, 10, 4'd3,  4'd0,  1'b0, 12'd260, 1, 8'd4};
        tbl[1]  = '{0, 0, 3'b010, 8'hF0,  4, 4'd3,  4'd14, 1'b0, 12'd104, 0, 8'd0};
        tbl[2]  = '{0, 0, 3'b000, 8'h00,  8, 4'd3,  4'd12, 1'b0, 12'd208, 0, 8'd0};
        tbl[3]  = '{0, 0, 3'b100, 8'h80,  1, 4'd3,  4'd12, 1'b1, 12'd26,  0, 8'd0};
        tbl[4]  = '{0, 0, 3'b100, 8'h7F,  3, 4'd3,  4'd11, 1'b0, 12'd78,  0, 8'd0};
        tbl[5]  = '{0, 0, 3'b001, 8'hFF,  2, 4'd15, 4'd10, 1'b0, 12'd196, 0, 8'd0};
        tbl[6]  = '{0, 0, 3'b101, 8'h85,  1, 4'd5,  4'd9,  1'b1, 12'd38,  0, 8'd0};
        tbl[7]  = '{0, 1, 3'b000, 8'h00,  1, 4'd5,  4'd0,  1'b0, 12'd38,  1, 8'd0};
        tbl[8]  = '{0, 1, 3'b010, 8'hF0,  2, 4'd5,  4'd0,  1'b0, 12'd76,  1, 8'd0};
        tbl[9]  = '{0, 0, 3'b001, 8'h00,  5, 4'd0,  4'd0,  1'b0, 12'd40,  0, 8'd0};
        tbl[10] = '{0, 0, 3'b010, 8'h35, 12, 4'd0,  4'd0,  1'b0, 12'd96,  0, 8'd0};
        tbl[11] = '{0, 0, 3'b000, 8'h00,  4, 4'd0,  4'd0,  1'b0, 12'd32,  0, 8'd0};
        tbl[12] = '{0, 0, 3'b010, 8'h1F,  3, 4'd0,  4'd1,  1'b0, 12'd24,  0, 8'd0};
        tbl[13] = '{0, 0, 3'b001, 8'h0F, 50, 4'd15, 4'd0,  1'b0, 12'd804, 0, 8'd0};

        // Reset hold, LFSR sequence and a long motor strobe
        MotorSnd_n = 1'b0;
        DBus       = 8'h03;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk6);
            if (Audio_S !== 8'd0 || Audio_O !== 1'b0) bad++;
        end
        check("reset_outputs", bad, 0);
        check("reset_state", {dut.lfsr, dut.motor_acc, dut.motor_spd},
              {16'hACE1, 12'd0, 4'd0});
        #1 Reset_n = 1'b1;
        lf  = 16'hACE1;
        bad = 0;
        for (int e = 1; e <= 64; e++) begin
            @(negedge Clk6);
            if (e % 4 == 0) begin
                lf = lfsr_next(lf);
                if (dut.lfsr !== lf) bad++;
            end
            if (e == 2)  check("motor_first_write", dut.motor_spd, 4'd3);
            if (e == 3)  DBus = 8'h0F;
            if (e == 4)  check("lfsr_first", dut.lfsr, 16'h59C3);
            if (e == 8) begin
                check("motor_held_low", dut.motor_spd, 4'd3);
                MotorSnd_n = 1'b1;
            end
            if (e == 40) check("motor_acc_10_ticks", dut.motor_acc, 12'd260);
            if (e == 41) check("audio_s_motor", Audio_S, 8'd4);
        end
        check("lfsr_16_ticks", bad, 0);

        // Crash rewrite landing on a decrement tick
        CrashSnd_n = 1'b0;
        DBus       = 8'hF0;
        @(negedge Clk6);
        #1 Reset_n = 1'b0;
        repeat (2) @(negedge Clk6);
        #1 Reset_n = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            @(negedge Clk6);
            if (e == 2) begin
                check("crash_write", dut.crash_amp, 4'd15);
                CrashSnd_n = 1'b1;
            end
            if (e == 12) check("crash_before_dec", dut.crash_amp, 4'd15);
            if (e == 14) CrashSnd_n = 1'b0;
            if (e == 16) begin
                check("crash_rewrite_wins", {dut.crash_amp, 4'(dut.decay_cnt)}, {4'd15, 4'd0});
                CrashSnd_n = 1'b1;
            end
            if (e == 28) check("crash_hold_after_rewrite", dut.crash_amp, 4'd15);
            if (e == 32) check("crash_dec_after_rewrite", dut.crash_amp, 4'd14);
        end

        // Table of single-shot writes, each aligned just after a tick
        for (int r = 0; r < 14; r++) begin
            if (tbl[r].rst) do_reset();
            Attract = tbl[r].attract;
            wait_ticks(1);
            MotorSnd_n = ~tbl[r].strb[0];
            CrashSnd_n = ~tbl[r].strb[1];
            SkidSnd_n  = ~tbl[r].strb[2];
            DBus       = tbl[r].dbus;
            repeat (2) @(negedge Clk6);
            MotorSnd_n = 1'b1;
            CrashSnd_n = 1'b1;
            SkidSnd_n  = 1'b1;
            acc0 = dut.motor_acc;
            wait_ticks(tbl[r].ticks);
            d = dut.motor_acc - acc0;
            check($sformatf("row%0d_spd_crash_skid_dacc", r),
                  {dut.motor_spd, dut.crash_amp, dut.skid_on, d},
                  {tbl[r].spd, tbl[r].crash, tbl[r].skid, tbl[r].delta});
            if (tbl[r].chk_s) begin
                @(negedge Clk6);
                check($sformatf("row%0d_audio_s", r), Audio_S, tbl[r].exp_s);
            end
        end

        // Attract mutes the sample, so the bitstream must sit at 0
        Attract = 1'b1;
        wait_ticks(2);
        @(negedge Clk6);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge Clk6);
            if (Audio_S !== 8'd0 || Audio_O !== 1'b0) bad++;
        end
        check("attract_silent", bad, 0);

        // Asynchronous reset in the middle of active strobes
        Attract = 1'b0;
        wait_ticks(1);
        MotorSnd_n = 1'b0;
        CrashSnd_n = 1'b0;
        DBus       = 8'hF7;
        repeat (2) @(negedge Clk6);
        check("pre_reset_writes", {dut.motor_spd, dut.crash_amp}, {4'd7, 4'd15});
        #1 Reset_n = 1'b0;
        #1 check("mid_reset_state",
                 {dut.motor_spd, dut.crash_amp, dut.skid_on, dut.motor_acc, dut.lfsr, Audio_S, Audio_O},
                 {4'd0, 4'd0, 1'b0, 12'd0, 16'hACE1, 8'd0, 1'b0});
        MotorSnd_n = 1'b1;
        CrashSnd_n = 1'b1;
        @(negedge Clk6);
        #1 Reset_n = 1'b1;
        repeat (10) @(negedge Clk6);
        check("post_reset_no_write", {dut.motor_spd, dut.crash_amp}, {4'd0, 4'd0});

        check("ds_duty_errors", ds_errs, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sound_gen.md
Name: sound_gen

Overview:
Sound generator for the Super Bug board. It consumes the CPU sound strobes (MotorSnd_n, CrashSnd_n, SkidSnd_n), the CPU data bus and Attract. It synthesizes three voices:
- motor: tone whose pitch is set by the latched speed value
- crash: decaying noise
- skid: gated noise

It mixes them into an 8-bit sample and drives the 1-bit Audio_O pin through a first-order delta-sigma modulator.

Parameters:
PRESCALE, 64, Clk6 cycles per sound tick (≥2); tick rate 93.75 kHz at default.
MOTOR_BASE, 12'd8, motor phase increment at speed 0.
MOTOR_STEP, 12'd6, added increment per unit of motor speed.
DECAY_TICKS, 4096, ticks between crash amplitude decrements (≥1).
SKID_AMP, 4'd10, skid voice level when noise bit is 1.

Ports:
Clk6  in  1  6 MHz system clock.
Reset_n  in  1  asynchronous active-low reset.
Attract  in  1  attract mode, high = mute.
MotorSnd_n  in  1  active-low motor-speed write strobe (may stay low many cycles).
CrashSnd_n  in  1  active-low crash-amplitude write strobe.
SkidSnd_n  in  1  active-low skid-enable write strobe.
DBus  in  8  CPU data out (CPU_Dout).
Audio_S  out  8  mixed sample.
Audio_O  out  1  delta-sigma audio bitstream.

Behaviour:
Clock and reset:
- Single clock Clk6; Reset_n is asynchronous, active-low.
- Reset values: Audio_S=0, Audio_O=0, prescaler=0, motor_spd=0, motor_acc=0, crash_amp=0, decay_cnt=0, skid_on=0, lfsr=16'hACE1, ds_acc=0, strobe history regs=1.

Strobes:
- Each strobe is registered once; a write is a falling edge (prev=1, cur=0).
- DBus is sampled in the same cycle the edge is detected.
- A strobe held low N cycles produces exactly one write.
- Writes on different strobes in the same cycle are all taken.
- MotorSnd write: motor_spd <= DBus[3:0].
- CrashSnd write: crash_amp <= DBus[7:4] and decay_cnt <= 0.
- SkidSnd write: skid_on <= DBus[7].

Tick:
- The prescaler counts 0..PRESCALE-1 and wraps.
- tick=1 for one cycle when the count equals PRESCALE-1.

On each tick:
- motor_acc (12-bit) += MOTOR_BASE + motor_spd*MOTOR_STEP, modulo 4096 (wraps silently).
- lfsr shifts left: feedback = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10], inserted at bit 0. The all-zero state is unreachable from the seed.
- Crash decay:
  - If crash_amp≠0, decay_cnt increments; on reaching DECAY_TICKS-1 it clears and crash_amp decrements.
  - crash_amp saturates at 0; decay_cnt holds at 0 while crash_amp=0.
  - A crash write in the same cycle as a decrement wins.

Mixer:
- Registered, updated on the cycle after a tick, using values post-tick.
- motor_lvl = motor_acc[11:8].
- crash_lvl = lfsr[0] ? crash_amp : 0.
- skid_lvl = (skid_on & lfsr[3]) ? SKID_AMP : 0.
- sum = motor_lvl + crash_lvl + skid_lvl (6-bit, max 45).
- Audio_S <= {sum,2'b00} (max 180; no overflow).

Attract:
- While Attract=1: crash_amp and skid_on are held cleared, and Audio_S <= 0 at the next mixer update.
- motor_spd and motor_acc keep running.
- Strobe writes are ignored for crash and skid while Attract=1.

Delta-sigma:
- Runs every Clk6 cycle: {carry, ds_acc} = ds_acc + Audio_S (9-bit).
- Audio_O <= carry, registered.
- Latency from an Audio_S change to the first affected Audio_O bit is 1 cycle.
- Long-run duty = Audio_S/256.

Reset mid-operation: all state returns to reset values immediately; no partial writes survive.

Test Plan:
1. Reset → Audio_S=0, Audio_O=0 for all cycles while Reset_n=0; first 16 ticks after release reproduce the LFSR sequence from 16'hACE1.
2. Motor (PRESCALE=4), MotorSnd_n low 8 cycles with DBus=8'h03, Attract=0 → single write; motor_spd=3; motor_acc +26 per tick; after 10 ticks motor_acc=260 and motor_lvl=1.
3. Crash (DECAY_TICKS=4), CrashSnd_n edge with DBus=8'hF0 → crash_amp=15; decrements every 4 ticks; 0 after 60 ticks, then stays 0. A rewrite on a decrement tick reloads 15.
4. Attract: skid_on=1 and crash_amp=9, then Attract=1 → both 0 and Audio_S=0 after next tick; CrashSnd write with 8'hF0 ignored; motor_acc still advancing.
5. Delta-sigma: force a constant Audio_S=8'h80 (motor only, lfsr-dependent voices off) → Audio_O alternates 1,0 with exactly 128 ones per 256 cycles; Audio_S=0 → Audio_O constantly 0.
6. Simultaneous: MotorSnd_n and SkidSnd_n fall in the same cycle, DBus=8'h85 → motor_spd=5, skid_on=1.
